// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: CPU-wide word/address widths, instruction fields, reset PC and fetch FSM states
package instruction_fetch_pkg;

    localparam int WORD_WIDTH = 16;
    localparam int ADDR_WIDTH = 16;

    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 9;
    localparam int OP0_MSB = 8;
    localparam int OP0_LSB = 6;
    localparam int OP1_MSB = 5;
    localparam int OP1_LSB = 3;
    localparam int OP2_MSB = 2;
    localparam int OP2_LSB = 0;

    localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {IDLE, REQ, REQ_DISCARD} fetchState_t;

endpackage

// File: rtl/instruction_fetch_buffer.sv
// fetch_buffer: DEPTH-entry FIFO of fetched {address, word} pairs with single-cycle flush
module fetch_buffer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic notReset,
    input  logic push,
    input  logic [ADDR_WIDTH-1:0] pushAddr,
    input  logic [instruction_fetch_pkg::WORD_WIDTH-1:0] pushWord,
    input  logic pop,
    input  logic flush,
    output logic [ADDR_WIDTH-1:0] headAddr,
    output logic [instruction_fetch_pkg::WORD_WIDTH-1:0] headWord,
    output logic [$clog2(DEPTH):0] count,
    output logic empty,
    output logic full
);
    import instruction_fetch_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0] addrMem [DEPTH];
    logic [WORD_WIDTH-1:0] wordMem [DEPTH];
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;

    assign headAddr = addrMem[rdPtr];
    assign headWord = wordMem[rdPtr];
    assign empty = count == '0;
    assign full = count == CW'(DEPTH);

    // Storage is unreset: only entries covered by count are ever read out
    always_ff @(posedge clock) begin
        if (push) begin
            addrMem[wrPtr] <= pushAddr;
            wordMem[wrPtr] <= pushWord;
        end
    end

    // Pointers and occupancy; a flush discards everything regardless of push/pop
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else if (flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop) rdPtr <= rdPtr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: prefetches instruction words over a req/ack port and strobes them into the IR on demand
module instruction_fetch #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(instruction_fetch_pkg::RESET_PC)
) (
    input  logic clock,
    input  logic notReset,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic memReq,
    input  logic memAck,
    input  logic [instruction_fetch_pkg::WORD_WIDTH-1:0] memData,
    input  logic next,
    input  logic jump,
    input  logic [ADDR_WIDTH-1:0] jumpAddr,
    output logic [instruction_fetch_pkg::WORD_WIDTH-1:0] irData,
    output logic irNotLoad,
    output logic [ADDR_WIDTH-1:0] irPc,
    output logic empty
);
    import instruction_fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    fetchState_t state;
    logic [ADDR_WIDTH-1:0] fetchPc;
    logic [ADDR_WIDTH-1:0] pcNext;
    logic [ADDR_WIDTH-1:0] headAddr;
    logic [WORD_WIDTH-1:0] headWord;
    logic [CW-1:0] count;
    logic [CW-1:0] countNext;
    logic push;
    logic pop;
    logic full;
    logic waiting;

    assign pop = next && !empty && !jump;
    assign push = state == REQ && memAck && !jump && (!full || pop);
    assign waiting = memReq && !memAck;
    assign pcNext = jump ? jumpAddr : push ? fetchPc + 1'b1 : fetchPc;
    assign countNext = jump ? '0 : count + CW'(push) - CW'(pop);

    fetch_buffer #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DEPTH(DEPTH)
    ) buffer (
        .clock(clock),
        .notReset(notReset),
        .push(push),
        .pushAddr(memAddr),
        .pushWord(memData),
        .pop(pop),
        .flush(jump),
        .headAddr(headAddr),
        .headWord(headWord),
        .count(count),
        .empty(empty),
        .full(full)
    );

    // Request FSM: hold a request until acked, then reissue as soon as the buffer will have room
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            state <= IDLE;
            fetchPc <= RESET_PC;
            memAddr <= RESET_PC;
            memReq <= 1'b0;
        end else begin
            fetchPc <= pcNext;
            if (waiting) begin
                if (jump) state <= REQ_DISCARD;
            end else if (int'(countNext) < DEPTH) begin
                state <= REQ;
                memReq <= 1'b1;
                memAddr <= pcNext;
            end else begin
                state <= IDLE;
                memReq <= 1'b0;
            end
        end
    end

    // Instruction register drive: strobe low for the single cycle after each pop
    always_ff @(posedge clock or negedge notReset) begin
        if (!notReset) begin
            irData <= '0;
            irPc <= '0;
            irNotLoad <= 1'b1;
        end else begin
            irNotLoad <= !pop;
            if (pop) begin
                irData <= headWord;
                irPc <= headAddr;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized traffic checked against a queue-based fetch model
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] word;
    } entry_t;

    logic clock = 1'b0;
    logic notReset = 1'b0;
    logic [15:0] memAddr;
    logic memReq;
    logic memAck = 1'b0;
    logic [15:0] memData = '0;
    logic next = 1'b0;
    logic jump = 1'b0;
    logic [15:0] jumpAddr = '0;
    logic [15:0] irData;
    logic irNotLoad;
    logic [15:0] irPc;
    logic empty;

    int checks = 0;
    int fails = 0;

    entry_t q[$];
    logic [15:0] mPc, mAddr, mIrData, mIrPc;
    logic mReq, mDisc, mNotLoad;

    instruction_fetch #(
        .ADDR_WIDTH(16),
        .DEPTH(DEPTH),
        .RESET_PC(16'h0000)
    ) dut (
        .clock(clock),
        .notReset(notReset),
        .memAddr(memAddr),
        .memReq(memReq),
        .memAck(memAck),
        .memData(memData),
        .next(next),
        .jump(jump),
        .jumpAddr(jumpAddr),
        .irData(irData),
        .irNotLoad(irNotLoad),
        .irPc(irPc),
        .empty(empty)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5AC3;
    endfunction

    task automatic modelReset();
        q.delete();
        mPc = 16'h0000;
        mAddr = 16'h0000;
        mReq = 1'b0;
        mDisc = 1'b0;
        mNotLoad = 1'b1;
        mIrData = '0;
        mIrPc = '0;
    endtask

    task automatic applyReset();
        {next, jump, memAck} = '0;
        jumpAddr = '0;
        notReset = 1'b0;
        @(posedge clock);
        #1;
        notReset = 1'b1;
        modelReset();
    endtask

    // Drive one cycle of inputs, advance the reference model, and land #1 after the next edge
    task automatic drive(input logic n, input logic j, input logic [15:0] ja, input logic ack);
        entry_t e;
        next = n;
        jump = j;
        jumpAddr = ja;
        memAck = ack;
        memData = memWord(memAddr);
        mNotLoad = !(n && q.size() != 0 && !j);
        if (!mNotLoad) begin
            e = q.pop_front();
            mIrData = e.word;
            mIrPc = e.addr;
        end
        if (mReq && ack && !mDisc && !j) begin
            q.push_back('{mAddr, memWord(mAddr)});
            mPc = mPc + 16'd1;
        end
        if (j) begin
            q.delete();
            mPc = ja;
        end
        if (mReq && !ack) begin
            mDisc = mDisc || j;
        end else begin
            mDisc = 1'b0;
            mReq = q.size() < DEPTH;
            if (mReq) mAddr = mPc;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        notReset = 1'b0;
        #12;
        checks++; if (memReq !== 1'b0) begin fails++; $display("FAIL reset_memReq: got %b want 0", memReq); end
        checks++; if (memAddr !== 16'h0000) begin fails++; $display("FAIL reset_memAddr: got %h want 0000", memAddr); end
        checks++; if (irNotLoad !== 1'b1) begin fails++; $display("FAIL reset_irNotLoad: got %b want 1", irNotLoad); end
        checks++; if (irData !== 16'h0000 || irPc !== 16'h0000) begin fails++; $display("FAIL reset_ir: got data %h pc %h want 0000 0000", irData, irPc); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        applyReset();
    endtask

    task automatic test_stream();
        applyReset();
        for (int k = 1; k <= 12; k++) begin
            drive(1'b1, 1'b0, 16'h0000, memReq);
            checks++; if (memReq !== 1'b1 || memAddr !== 16'(k - 1)) begin fails++; $display("FAIL stream_addr[%0d]: got req %b addr %h want 1 %h", k, memReq, memAddr, 16'(k - 1)); end
            if (k >= 3) begin
                checks++;
                if (irNotLoad !== 1'b0 || irPc !== 16'(k - 3) || irData !== memWord(16'(k - 3))) begin
                    fails++;
                    $display("FAIL stream_ir[%0d]: got load %b pc %h data %h want 0 %h %h", k, irNotLoad, irPc, irData, 16'(k - 3), memWord(16'(k - 3)));
                end
            end
        end
    endtask

    task automatic test_fill();
        int acks = 0;
        applyReset();
        for (int i = 0; i < 6; i++) begin
            acks += int'(memReq);
            drive(1'b0, 1'b0, 16'h0000, memReq);
        end
        checks++; if (acks != DEPTH) begin fails++; $display("FAIL fill_requests: got %0d want %0d", acks, DEPTH); end
        checks++; if (memReq !== 1'b0 || empty !== 1'b0) begin fails++; $display("FAIL fill_idle: got req %b empty %b want 0 0", memReq, empty); end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b0 || irPc !== 16'h0000 || irData !== memWord(16'h0000)) begin fails++; $display("FAIL fill_pop: got load %b pc %h data %h want 0 0000 %h", irNotLoad, irPc, irData, memWord(16'h0000)); end
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0002) begin fails++; $display("FAIL fill_refetch: got req %b addr %h want 1 0002", memReq, memAddr); end
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b1) begin fails++; $display("FAIL fill_strobe_end: got %b want 1", irNotLoad); end
    endtask

    task automatic test_jump_discard();
        bit found = 1'b0;
        applyReset();
        for (int i = 0; i < 20 && !found; i++) begin
            if (memReq === 1'b1 && memAddr === 16'h0003) found = 1'b1;
            else drive(1'b1, 1'b0, 16'h0000, memReq);
        end
        checks++; if (!found) begin fails++; $display("FAIL jd_reach_addr3: got addr %h want 0003 within 20 cycles", memAddr); end
        drive(1'b0, 1'b1, 16'h0100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (memReq !== 1'b1 || memAddr !== 16'h0003 || empty !== 1'b1 || irNotLoad !== 1'b1) begin
                fails++;
                $display("FAIL jd_hold[%0d]: got req %b addr %h empty %b load %b want 1 0003 1 1", i, memReq, memAddr, empty, irNotLoad);
            end
            drive(1'b1, 1'b0, 16'h0000, i == 3);
        end
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0100 || empty !== 1'b1 || irNotLoad !== 1'b1) begin fails++; $display("FAIL jd_redirect: got req %b addr %h empty %b load %b want 1 0100 1 1", memReq, memAddr, empty, irNotLoad); end
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++; if (empty !== 1'b0 || irNotLoad !== 1'b1) begin fails++; $display("FAIL jd_fill: got empty %b load %b want 0 1", empty, irNotLoad); end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b0 || irPc !== 16'h0100 || irData !== memWord(16'h0100)) begin fails++; $display("FAIL jd_deliver: got load %b pc %h data %h want 0 0100 %h", irNotLoad, irPc, irData, memWord(16'h0100)); end
    endtask

    task automatic test_jump_ack_next();
        applyReset();
        drive(1'b0, 1'b0, 16'h0000, memReq);
        drive(1'b0, 1'b0, 16'h0000, memReq);
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0001 || empty !== 1'b0) begin fails++; $display("FAIL jan_setup: got req %b addr %h empty %b want 1 0001 0", memReq, memAddr, empty); end
        drive(1'b1, 1'b1, 16'h0200, 1'b1);
        checks++; if (irNotLoad !== 1'b1 || empty !== 1'b1) begin fails++; $display("FAIL jan_no_strobe: got load %b empty %b want 1 1", irNotLoad, empty); end
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0200) begin fails++; $display("FAIL jan_refetch: got req %b addr %h want 1 0200", memReq, memAddr); end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (empty !== 1'b0 || memAddr !== 16'h0201) begin fails++; $display("FAIL jan_fill: got empty %b addr %h want 0 0201", empty, memAddr); end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b0 || irPc !== 16'h0200 || irData !== memWord(16'h0200)) begin fails++; $display("FAIL jan_deliver: got load %b pc %h data %h want 0 0200 %h", irNotLoad, irPc, irData, memWord(16'h0200)); end
    endtask

    task automatic test_wrap();
        applyReset();
        drive(1'b0, 1'b1, 16'hFFFF, 1'b0);
        checks++; if (memReq !== 1'b1 || memAddr !== 16'hFFFF) begin fails++; $display("FAIL wrap_first: got req %b addr %h want 1 ffff", memReq, memAddr); end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0000) begin fails++; $display("FAIL wrap_second: got req %b addr %h want 1 0000", memReq, memAddr); end
        drive(1'b1, 1'b0, 16'h0000, 1'b1);
        checks++; if (irNotLoad !== 1'b0 || irPc !== 16'hFFFF || irData !== memWord(16'hFFFF)) begin fails++; $display("FAIL wrap_ir_ffff: got load %b pc %h data %h want 0 ffff %h", irNotLoad, irPc, irData, memWord(16'hFFFF)); end
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b0 || irPc !== 16'h0000 || irData !== memWord(16'h0000)) begin fails++; $display("FAIL wrap_ir_0000: got load %b pc %h data %h want 0 0000 %h", irNotLoad, irPc, irData, memWord(16'h0000)); end
    endtask

    task automatic test_async_reset();
        applyReset();
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 16'h0000, memReq);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b0 || empty !== 1'b0 || memReq !== 1'b1) begin fails++; $display("FAIL ar_setup: got load %b empty %b req %b want 0 0 1", irNotLoad, empty, memReq); end
        #2;
        notReset = 1'b0;
        #1;
        checks++; if (memReq !== 1'b0 || irNotLoad !== 1'b1 || empty !== 1'b1 || memAddr !== 16'h0000) begin fails++; $display("FAIL ar_immediate: got req %b load %b empty %b addr %h want 0 1 1 0000", memReq, irNotLoad, empty, memAddr); end
        @(posedge clock);
        #1;
        notReset = 1'b1;
        modelReset();
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        checks++; if (memReq !== 1'b1 || memAddr !== 16'h0000 || empty !== 1'b1) begin fails++; $display("FAIL ar_restart: got req %b addr %h empty %b want 1 0000 1", memReq, memAddr, empty); end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        checks++; if (irNotLoad !== 1'b0 || irPc !== 16'h0000 || irData !== memWord(16'h0000)) begin fails++; $display("FAIL ar_deliver: got load %b pc %h data %h want 0 0000 %h", irNotLoad, irPc, irData, memWord(16'h0000)); end
    endtask

    task automatic test_random();
        logic n, j, ack;
        logic [15:0] ja;
        for (int c = 0; c < 600; c++) begin
            checks++; if (memReq !== mReq) begin fails++; $display("FAIL rnd_memReq @%0d: got %b want %b", c, memReq, mReq); end
            checks++; if (mReq && memAddr !== mAddr) begin fails++; $display("FAIL rnd_memAddr @%0d: got %h want %h", c, memAddr, mAddr); end
            checks++; if (empty !== (q.size() == 0)) begin fails++; $display("FAIL rnd_empty @%0d: got %b want %b", c, empty, q.size() == 0); end
            checks++; if (irNotLoad !== mNotLoad) begin fails++; $display("FAIL rnd_irNotLoad @%0d: got %b want %b", c, irNotLoad, mNotLoad); end
            checks++; if (irData !== mIrData || irPc !== mIrPc) begin fails++; $display("FAIL rnd_ir @%0d: got data %h pc %h want %h %h", c, irData, irPc, mIrData, mIrPc); end
            n = $urandom_range(0, 3) != 0;
            j = $urandom_range(0, 24) == 0;
            ja = 16'($urandom);
            ack = memReq ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 15) == 0);
            drive(n, j, ja, ack);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        modelReset();
        test_reset();
        test_stream();
        test_fill();
        test_jump_discard();
        test_jump_ack_next();
        test_wrap();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
